// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// Used by the RTL and by the testbench.
package seq_det_pkg;

    localparam int MAX_LEN_LIMIT = 32;
    localparam int CNT_W_LIMIT   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    // A pattern length is usable when it names at least one bit and fits the history.
    function automatic logic len_legal(input int len, input int max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

    function automatic logic params_legal(input int max_len, input int cnt_w);
        return (max_len >= 2) && (max_len <= MAX_LEN_LIMIT) &&
               (cnt_w >= 1) && (cnt_w <= CNT_W_LIMIT);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter: advances on inc and holds at all-ones.
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control.
// Define SEQ_DET_COUNT_EN to add the saturating match_count output.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               din_valid,
    input  logic               din,
    output logic               dout,
    output logic               cfg_err,
`ifdef SEQ_DET_COUNT_EN
    output logic               active,
    output logic [CNT_W-1:0]   match_count
`else
    output logic               active
`endif
);

    // Out-of-range parameters leave the block permanently inactive.
    localparam logic PARAMS_OK = params_legal(MAX_LEN, CNT_W);

    state_t             state_q,  state_d;
    logic [MAX_LEN-1:0] hist_q,   hist_d;
    logic [LEN_W-1:0]   fill_q,   fill_d;
    logic [MAX_LEN-1:0] pat_q,    pat_d;
    logic [LEN_W-1:0]   len_q,    len_d;
    logic               ovl_q,    ovl_d;
    logic               dout_q,   dout_d;
    logic               err_q,    err_d;
    logic               active_q, active_d;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_next;
    logic               fill_full;
    logic               hit;
    logic               cfg_ok;

    // Compare only the low len_q bits; higher pattern bits are don't-care.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign hist_shift = {hist_q[MAX_LEN-2:0], din};
    assign fill_next  = (fill_q == len_q) ? fill_q : fill_q + LEN_W'(1);
    assign fill_full  = (fill_next == len_q);
    assign hit        = fill_full && (((hist_shift ^ pat_q) & len_mask) == '0);
    assign cfg_ok     = PARAMS_OK && len_legal(int'(cfg_len), MAX_LEN);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d  = state_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        pat_d    = pat_q;
        len_d    = len_q;
        ovl_d    = ovl_q;
        dout_d   = 1'b0;
        err_d    = err_q;
        active_d = active_q;

        if (cfg_load) begin
            hist_d = '0;
            fill_d = '0;
            if (cfg_ok) begin
                pat_d    = cfg_pattern;
                len_d    = cfg_len;
                ovl_d    = cfg_overlap;
                err_d    = 1'b0;
                active_d = 1'b1;
                state_d  = FILL;
            end else begin
                pat_d    = '0;
                len_d    = '0;
                ovl_d    = 1'b0;
                err_d    = 1'b1;
                active_d = 1'b0;
                state_d  = IDLE;
            end
        end else if (din_valid && (state_q != IDLE)) begin
            hist_d  = hist_shift;
            fill_d  = fill_next;
            state_d = fill_full ? RUN : FILL;
            if (hit) begin
                dout_d = 1'b1;
                // Non-overlapping mode demands cfg_len fresh bits before the next match.
                if (!ovl_q) begin
                    fill_d  = '0;
                    state_d = FILL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the history is reset along with the control state so a stale pattern can never match.
        if (!resetn) begin
            state_q  <= IDLE;
            hist_q   <= '0;
            fill_q   <= '0;
            pat_q    <= '0;
            len_q    <= '0;
            ovl_q    <= 1'b0;
            dout_q   <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            hist_q   <= hist_d;
            fill_q   <= fill_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            ovl_q    <= ovl_d;
            dout_q   <= dout_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    assign dout    = dout_q;
    assign cfg_err = err_q;
    assign active  = active_q;

`ifdef SEQ_DET_COUNT_EN
    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk    (clk),
        .resetn (resetn),
        .inc    (dout_d),
        .count  (match_count)
    );
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param; honours SEQ_DET_COUNT_EN for match_count.
module tb_seq_detector_param;
    import seq_det_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               resetn;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               din_valid;
    logic               din;
    logic               dout;
    logic               cfg_err;
    logic               active;
`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0]   match_count;
`endif

    always #5 clk = ~clk;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .din_valid   (din_valid),
        .din         (din),
        .dout        (dout),
        .cfg_err     (cfg_err),
`ifdef SEQ_DET_COUNT_EN
        .active      (active),
        .match_count (match_count)
`else
        .active      (active)
`endif
    );

    typedef struct packed {
        logic             dout;
        logic             err;
        logic             act;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: a queue of the most recent consumed bits, oldest first.
    bit               m_act = 1'b0;
    bit               m_err = 1'b0;
    int               m_len = 0;
    logic [MAX_LEN-1:0] m_pat = '0;
    bit               m_ovl = 1'b0;
    int               m_cnt = 0;
    bit               m_hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rn, input logic ld, input logic [MAX_LEN-1:0] pat,
                        input int len, input logic ovl, input logic v, input logic d,
                        input string tag);
        exp_t e;
        bit   m;
        e.dout = 1'b0;
        if (!rn) begin
            m_act = 1'b0;
            m_err = 1'b0;
            m_cnt = 0;
            m_hist.delete();
        end else if (ld) begin
            m_hist.delete();
            if (len_legal(len, MAX_LEN)) begin
                m_pat = pat;
                m_len = len;
                m_ovl = ovl;
                m_act = 1'b1;
                m_err = 1'b0;
            end else begin
                m_act = 1'b0;
                m_err = 1'b1;
            end
        end else if (v && m_act) begin
            m_hist.push_back(d);
            if (m_hist.size() > m_len) void'(m_hist.pop_front());
            m = (m_hist.size() == m_len);
            for (int i = 0; i < m_hist.size(); i++) begin
                if (m_hist[i] != m_pat[m_len-1-i]) m = 1'b0;
            end
            if (m) begin
                e.dout = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
                if (!m_ovl) m_hist.delete();
            end
        end
        e.err = m_err;
        e.act = m_act;
        e.cnt = CNT_W'(m_cnt);
        exp_q.push_back(e);

        resetn      = rn;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = LEN_W'(len);
        cfg_overlap = ovl;
        din_valid   = v;
        din         = d;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".dout"}, 32'(dout), 32'(e.dout));
        check({tag, ".cfg_err"}, 32'(cfg_err), 32'(e.err));
        check({tag, ".active"}, 32'(active), 32'(e.act));
`ifdef SEQ_DET_COUNT_EN
        check({tag, ".match_count"}, 32'(match_count), 32'(e.cnt));
`endif
    endtask

    task automatic do_reset(input string tag);
        step(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0, tag);
    endtask

    task automatic load(input logic [MAX_LEN-1:0] pat, input int len, input logic ovl,
                        input string tag);
        step(1'b1, 1'b1, pat, len, ovl, 1'b0, 1'b0, tag);
    endtask

    task automatic bit_in(input logic v, input logic d, input string tag);
        step(1'b1, 1'b0, '0, 0, 1'b0, v, d, tag);
    endtask

    // Feeds n valid bits of seq, most significant of the n first.
    task automatic bits(input logic [31:0] seq, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) bit_in(1'b1, seq[i], tag);
    endtask

    initial begin
        resetn = 1'b0; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; din_valid = 1'b0; din = 1'b0;

        do_reset("rst0");
        do_reset("rst1");
        bit_in(1'b1, 1'b1, "idle_din");

        // Overlapping 1010 over 101010
        load(8'b0000_1010, 4, 1'b1, "ovl_load");
        bits(32'b10_1010, 6, "ovl");
        bit_in(1'b0, 1'b0, "ovl_gap");

        // Non-overlapping: second match needs fresh bits
        do_reset("nov_rst");
        load(8'b0000_1010, 4, 1'b0, "nov_load");
        bits(32'b1010_1010, 8, "nov");

        // Valid gaps, don't-care upper pattern bits, restart by reload
        do_reset("gap_rst");
        load(8'b1111_0110, 3, 1'b1, "gap_load");
        bit_in(1'b1, 1'b1, "gap_b0");
        bit_in(1'b0, 1'b0, "gap_idle");
        bit_in(1'b1, 1'b1, "gap_b1");
        bit_in(1'b0, 1'b1, "gap_idle");
        bit_in(1'b0, 1'b0, "gap_idle");
        bit_in(1'b1, 1'b0, "gap_b2");
        bit_in(1'b0, 1'b0, "gap_after");
        bits(32'b11, 2, "part");
        step(1'b1, 1'b1, 8'b0000_0110, 3, 1'b1, 1'b1, 1'b0, "reload_with_din");
        bit_in(1'b1, 1'b0, "lost_tail");
        bits(32'b110, 3, "fresh");

        // Illegal lengths then recovery
        load(8'hA5, 0, 1'b1, "bad_len0");
        for (int i = 0; i < 20; i++) bit_in(1'b1, 1'($urandom_range(0, 1)), "bad0_din");
        load(8'hA5, MAX_LEN + 1, 1'b1, "bad_len9");
        for (int i = 0; i < 20; i++) bit_in(1'b1, 1'($urandom_range(0, 1)), "bad9_din");
        load(8'b1100_1010, MAX_LEN, 1'b0, "full_load");
        bits(32'b1100_1010, 8, "full");

        // Length 1 with counter saturation
        do_reset("sat_rst");
        load(8'b0000_0001, 1, 1'b0, "sat_load");
        bits(32'b11_1111, 6, "sat");
        bit_in(1'b1, 1'b0, "sat_zero");

        // Reset lands on the edge that would consume the final bit
        do_reset("mid_rst0");
        load(8'b0000_1010, 4, 1'b1, "mid_load");
        bits(32'b101, 3, "mid");
        step(1'b0, 1'b0, '0, 0, 1'b0, 1'b1, 1'b0, "mid_rst");
        bit_in(1'b0, 1'b0, "mid_after");
        bits(32'b1010, 4, "mid_noconfig");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
